sys_ctrl_gen2: RTL and testbench

Parametrised second-generation system controller for the REF_CLK domain. It parses command frames arriving from the synchronised UART RX byte stream, drives the register file and the gated ALU, and pushes response bytes into the TX FIFO. Compared with the first-generation controller it adds:
- generic data, address and ALU widths, with multi-byte ALU results serialised LSB-first;
- a burst-read command;
- an inter-byte frame timeout;
- error-byte responses.

---
 rtl/sys_ctrl_gen2.sv | 265 ++++++++++++++++++++++++++
 tb/tb_sys_ctrl_gen2.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_gen2.sv
// Second-generation REF_CLK system controller: parses UART command frames, drives the
// register file and gated ALU, and serialises responses into the TX FIFO.
module sys_ctrl_gen2 #(
    parameter int unsigned           DATA_WIDTH    = 8,
    parameter int unsigned           Address_bits  = 4,
    parameter int unsigned           ALU_FUN_WIDTH = 4,
    parameter int unsigned           ALU_OUT_WIDTH = 16,
    parameter int unsigned           TIMEOUT       = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_BYTE      = 8'hFF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    RdData,
    input  logic                     RdData_Valid,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     OUT_Valid,
    input  logic                     FIFO_FULL,
    output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
    output logic                     EN,
    output logic                     CLK_EN,
    output logic [Address_bits-1:0]  Address,
    output logic                     WrEn,
    output logic                     RdEn,
    output logic [DATA_WIDTH-1:0]    WrData,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     W_INC,
    output logic                     clk_div_en,
    output logic                     frame_err
);

    localparam int unsigned NBYTES = ALU_OUT_WIDTH / DATA_WIDTH;
    localparam int unsigned NB_W   = $clog2(NBYTES + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 2);

    localparam logic [DATA_WIDTH-1:0] CMD_WR    = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD    = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU   = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALUNO = DATA_WIDTH'(8'hDD);
    localparam logic [DATA_WIDTH-1:0] CMD_BURST = DATA_WIDTH'(8'hAB);

    typedef enum logic [3:0] {
        StIdle, StWrAddr, StWrData, StRdAddr, StRdWait, StAluA, StAluB, StAluF,
        StAluWait, StBrAddr, StBrCnt, StBrRd, StSend, StErr
    } state_e;

    state_e                     state_q, state_d;
    logic [ALU_FUN_WIDTH-1:0]   alu_fun_q, alu_fun_d;
    logic                       en_q, en_d, clk_en_q, clk_en_d;
    logic [Address_bits-1:0]    addr_q, addr_d;
    logic                       wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic [DATA_WIDTH-1:0]      wr_data_q, wr_data_d, tx_data_q, tx_data_d;
    logic                       w_inc_q, w_inc_d, frame_err_q, frame_err_d;
    logic [ALU_OUT_WIDTH-1:0]   res_q, res_d;
    logic [NB_W-1:0]            nb_q, nb_d;
    logic [DATA_WIDTH-1:0]      br_cnt_q, br_cnt_d;
    logic [TMO_W-1:0]           tmo_q, tmo_d;

    logic                       byte_wait, timed_out, load, done;
    logic [ALU_OUT_WIDTH-1:0]   load_val;
    logic [NB_W-1:0]            load_n;

    always_comb begin
        state_d     = state_q;
        alu_fun_d   = alu_fun_q;
        en_d        = 1'b0;
        clk_en_d    = clk_en_q;
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        tx_data_d   = tx_data_q;
        w_inc_d     = 1'b0;
        frame_err_d = 1'b0;
        res_d       = res_q;
        nb_d        = nb_q;
        br_cnt_d    = br_cnt_q;
        tmo_d       = '0;
        load        = 1'b0;
        load_val    = '0;
        load_n      = '0;
        done        = 1'b0;

        byte_wait = state_q inside {StWrAddr, StWrData, StRdAddr, StAluA, StAluB, StAluF,
                                    StBrAddr, StBrCnt};
        // Counter holds cycles since the last accepted byte, so the abort lands on TIMEOUT.
        timed_out = byte_wait && !RX_D_VLD && (TIMEOUT != 0) &&
                    (32'(tmo_q) + 32'd1 >= TIMEOUT);

        if (TIMEOUT != 0) begin
            if (RX_D_VLD && (byte_wait || state_q == StIdle)) tmo_d = TMO_W'(1);
            else if (byte_wait && !timed_out)                 tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            StIdle: if (RX_D_VLD) begin
                case (RX_P_DATA)
                    CMD_WR:    state_d = StWrAddr;
                    CMD_RD:    state_d = StRdAddr;
                    CMD_ALU:   state_d = StAluA;
                    CMD_ALUNO: state_d = StAluF;
                    CMD_BURST: state_d = StBrAddr;
                    default: begin
                        frame_err_d = 1'b1;
                        state_d     = StErr;
                    end
                endcase
            end
            StWrAddr: if (RX_D_VLD) begin
                addr_d  = RX_P_DATA[Address_bits-1:0];
                state_d = StWrData;
            end
            StWrData: if (RX_D_VLD) begin
                wr_data_d = RX_P_DATA;
                wr_en_d   = 1'b1;
                state_d   = StIdle;
            end
            StRdAddr: if (RX_D_VLD) begin
                addr_d   = RX_P_DATA[Address_bits-1:0];
                rd_en_d  = 1'b1;
                br_cnt_d = '0;
                state_d  = StRdWait;
            end
            StRdWait, StBrRd: if (RdData_Valid) begin
                load     = 1'b1;
                load_val = ALU_OUT_WIDTH'(RdData);
                load_n   = NB_W'(1);
            end
            StAluA: if (RX_D_VLD) begin
                addr_d    = '0;
                wr_data_d = RX_P_DATA;
                wr_en_d   = 1'b1;
                state_d   = StAluB;
            end
            StAluB: if (RX_D_VLD) begin
                addr_d    = Address_bits'(1);
                wr_data_d = RX_P_DATA;
                wr_en_d   = 1'b1;
                state_d   = StAluF;
            end
            StAluF: if (RX_D_VLD) begin
                alu_fun_d = RX_P_DATA[ALU_FUN_WIDTH-1:0];
                en_d      = 1'b1;
                clk_en_d  = 1'b1;
                br_cnt_d  = '0;
                state_d   = StAluWait;
            end
            StAluWait: if (OUT_Valid) begin
                clk_en_d = 1'b0;
                load     = 1'b1;
                load_val = ALU_OUT;
                load_n   = NB_W'(NBYTES);
            end
            StBrAddr: if (RX_D_VLD) begin
                addr_d  = RX_P_DATA[Address_bits-1:0];
                state_d = StBrCnt;
            end
            StBrCnt: if (RX_D_VLD) begin
                if (RX_P_DATA == '0) begin
                    state_d = StIdle;
                end else begin
                    br_cnt_d = RX_P_DATA;
                    rd_en_d  = 1'b1;
                    state_d  = StBrRd;
                end
            end
            StSend: if (!FIFO_FULL) begin
                w_inc_d   = 1'b1;
                tx_data_d = res_q[DATA_WIDTH-1:0];
                res_d     = res_q >> DATA_WIDTH;
                nb_d      = nb_q - NB_W'(1);
                done      = (nb_q == NB_W'(1));
            end
            StErr: if (!FIFO_FULL) begin
                w_inc_d   = 1'b1;
                tx_data_d = ERR_BYTE;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (timed_out) begin
            frame_err_d = 1'b1;
            state_d     = StErr;
        end

        // Push the first byte in the capture cycle so the FIFO sees it one cycle later.
        if (load) begin
            if (!FIFO_FULL) begin
                w_inc_d   = 1'b1;
                tx_data_d = load_val[DATA_WIDTH-1:0];
                res_d     = load_val >> DATA_WIDTH;
                nb_d      = load_n - NB_W'(1);
                if (load_n == NB_W'(1)) done = 1'b1;
                else                    state_d = StSend;
            end else begin
                res_d   = load_val;
                nb_d    = load_n;
                state_d = StSend;
            end
        end

        if (done) begin
            if (br_cnt_q > DATA_WIDTH'(1)) begin
                addr_d   = addr_q + Address_bits'(1);
                rd_en_d  = 1'b1;
                br_cnt_d = br_cnt_q - DATA_WIDTH'(1);
                state_d  = StBrRd;
            end else begin
                br_cnt_d = '0;
                state_d  = StIdle;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            alu_fun_q   <= '0;
            en_q        <= 1'b0;
            clk_en_q    <= 1'b0;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_data_q   <= '0;
            tx_data_q   <= '0;
            w_inc_q     <= 1'b0;
            frame_err_q <= 1'b0;
            res_q       <= '0;
            nb_q        <= '0;
            br_cnt_q    <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            alu_fun_q   <= alu_fun_d;
            en_q        <= en_d;
            clk_en_q    <= clk_en_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            wr_data_q   <= wr_data_d;
            tx_data_q   <= tx_data_d;
            w_inc_q     <= w_inc_d;
            frame_err_q <= frame_err_d;
            res_q       <= res_d;
            nb_q        <= nb_d;
            br_cnt_q    <= br_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    assign ALU_FUN    = alu_fun_q;
    assign EN         = en_q;
    assign CLK_EN     = clk_en_q;
    assign Address    = addr_q;
    assign WrEn       = wr_en_q;
    assign RdEn       = rd_en_q;
    assign WrData     = wr_data_q;
    assign TX_P_DATA  = tx_data_q;
    assign W_INC      = w_inc_q;
    assign frame_err  = frame_err_q;
    assign clk_div_en = 1'b1;

endmodule

// File: tb/tb_sys_ctrl_gen2.sv
// Directed self-checking bench for sys_ctrl_gen2 with register-file and ALU responders.
module tb_sys_ctrl_gen2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_vld = 1'b0;
    logic [7:0]  rd_data = 8'h00;
    logic        rd_valid = 1'b0;
    logic [15:0] alu_out = 16'h0000;
    logic        out_valid = 1'b0;
    logic        fifo_full = 1'b0;
    logic [3:0]  alu_fun;
    logic        en, clk_en, wr_en, rd_en, w_inc, clk_div_en, frame_err;
    logic [3:0]  address;
    logic [7:0]  wr_data, tx_data;

    sys_ctrl_gen2 #(
        .DATA_WIDTH   (8),
        .Address_bits (4),
        .ALU_FUN_WIDTH(4),
        .ALU_OUT_WIDTH(16),
        .TIMEOUT      (16),
        .ERR_BYTE     (8'hFF)
    ) dut (
        .CLK         (clk),
        .RST         (rst_n),
        .RX_P_DATA   (rx_data),
        .RX_D_VLD    (rx_vld),
        .RdData      (rd_data),
        .RdData_Valid(rd_valid),
        .ALU_OUT     (alu_out),
        .OUT_Valid   (out_valid),
        .FIFO_FULL   (fifo_full),
        .ALU_FUN     (alu_fun),
        .EN          (en),
        .CLK_EN      (clk_en),
        .Address     (address),
        .WrEn        (wr_en),
        .RdEn        (rd_en),
        .WrData      (wr_data),
        .TX_P_DATA   (tx_data),
        .W_INC       (w_inc),
        .clk_div_en  (clk_div_en),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed side effects
    logic [7:0] mem [16];
    logic [7:0] tx_q [$];
    int         push_cyc [$];
    int         wr_count = 0, last_wr_cyc = 0, en_count = 0, en_cyc = 0;
    int         err_count = 0, err_cyc = 0, rd_en_count = 0;
    logic [3:0] last_wr_addr = 4'h0;
    logic [7:0] last_wr_data = 8'h00;
    logic       clk_en_at_en = 1'b0;

    always @(negedge clk) begin
        if (w_inc) begin
            tx_q.push_back(tx_data);
            push_cyc.push_back(cyc);
        end
        if (wr_en) begin
            mem[address] = wr_data;
            wr_count++;
            last_wr_cyc = cyc;
            last_wr_addr = address;
            last_wr_data = wr_data;
        end
        if (rd_en) rd_en_count++;
        if (en) begin
            en_count++;
            en_cyc = cyc;
            clk_en_at_en = clk_en;
        end
        if (frame_err) begin
            err_count++;
            err_cyc = cyc;
        end
    end

    // Register-file and ALU responders
    logic        rd_hold = 1'b0;
    logic [15:0] alu_val = 16'h0000;
    int          rdv_cyc = 0, outv_cyc = 0, alu_wait = 0;
    logic        clk_en_at_outv = 1'b0;

    always @(negedge clk) begin
        rd_valid = 1'b0;
        if (rd_en && !rd_hold) begin
            rd_valid = 1'b1;
            rd_data = mem[address];
            rdv_cyc = cyc;
        end
        out_valid = 1'b0;
        if (en) begin
            alu_wait = 3;
        end else if (alu_wait > 0) begin
            alu_wait--;
            if (alu_wait == 0) begin
                out_valid = 1'b1;
                alu_out = alu_val;
                outv_cyc = cyc;
                clk_en_at_outv = clk_en;
            end
        end
    end

    int byte_cyc = 0;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_vld = 1'b1;
        byte_cyc = cyc;
        @(negedge clk);
        rx_vld = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_tx();
        tx_q.delete();
        push_cyc.delete();
    endtask

    task automatic test_reset();
        logic [29:0] outs;
        wait_cyc(2);
        outs = {alu_fun, en, clk_en, address, wr_en, rd_en, wr_data, tx_data, w_inc, frame_err};
        total++;
        if (outs !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", outs);
        end
        total++;
        if (clk_div_en !== 1'b1) begin
            bad++; $display("FAIL reset_clk_div_en got=%b want=1", clk_div_en);
        end
        rst_n = 1'b1;
        wait_cyc(2);
    endtask

    task automatic test_write_read();
        int w0 = wr_count;
        clear_tx();
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        wait_cyc(3);
        total++;
        if (wr_count !== w0 + 1) begin
            bad++; $display("FAIL wr_count got=%0d want=%0d", wr_count, w0 + 1);
        end
        total++;
        if ({last_wr_addr, last_wr_data} !== {4'h5, 8'h3C}) begin
            bad++; $display("FAIL wr_addr_data got=%h/%h want=5/3c", last_wr_addr, last_wr_data);
        end
        total++;
        if (last_wr_cyc !== byte_cyc + 1) begin
            bad++; $display("FAIL wr_latency got=%0d want=%0d", last_wr_cyc, byte_cyc + 1);
        end
        send_byte(8'hBB); send_byte(8'h05);
        wait_cyc(6);
        total++;
        if (tx_q.size() !== 1) begin
            bad++; $display("FAIL rd_push_count got=%0d want=1", tx_q.size());
        end
        total++;
        if ((tx_q.size() > 0 ? tx_q[0] : 8'hxx) !== 8'h3C) begin
            bad++; $display("FAIL rd_data got=%h want=3c", tx_q.size() > 0 ? tx_q[0] : 8'hxx);
        end
        total++;
        if ((push_cyc.size() > 0 ? push_cyc[0] : -1) !== rdv_cyc + 1) begin
            bad++; $display("FAIL rd_latency got=%0d want=%0d",
                            push_cyc.size() > 0 ? push_cyc[0] : -1, rdv_cyc + 1);
        end
    endtask

    task automatic test_alu();
        int e0 = en_count;
        clear_tx();
        alu_val = 16'h000A;
        send_byte(8'hCC); send_byte(8'h07); send_byte(8'h03); send_byte(8'h00);
        wait_cyc(10);
        total++;
        if ({mem[0], mem[1]} !== 16'h0703) begin
            bad++; $display("FAIL alu_operands got=%h%h want=0703", mem[0], mem[1]);
        end
        total++;
        if (en_count !== e0 + 1 || en_cyc !== byte_cyc + 1 || clk_en_at_en !== 1'b1) begin
            bad++; $display("FAIL alu_en got=cnt%0d cyc%0d ce%b want=cnt%0d cyc%0d ce1",
                            en_count, en_cyc, clk_en_at_en, e0 + 1, byte_cyc + 1);
        end
        total++;
        if (tx_q.size() !== 2 || tx_q[0] !== 8'h0A || tx_q[1] !== 8'h00) begin
            bad++; $display("FAIL alu_bytes got=%p want='{0a,00}", tx_q);
        end
        total++;
        if (push_cyc.size() !== 2 || push_cyc[0] !== outv_cyc + 1 || push_cyc[1] !== outv_cyc + 2)
        begin
            bad++; $display("FAIL alu_push_timing got=%p want=%0d,%0d", push_cyc,
                            outv_cyc + 1, outv_cyc + 2);
        end
        total++;
        if ({clk_en_at_outv, clk_en} !== 2'b10) begin
            bad++; $display("FAIL alu_clk_en got=%b%b want=10", clk_en_at_outv, clk_en);
        end
    endtask

    task automatic test_burst();
        int r0;
        send_byte(8'hAA); send_byte(8'h0E); send_byte(8'h11);
        send_byte(8'hAA); send_byte(8'h0F); send_byte(8'h22);
        send_byte(8'hAA); send_byte(8'h00); send_byte(8'h33);
        wait_cyc(2);
        clear_tx();
        send_byte(8'hAB); send_byte(8'h0E); send_byte(8'h03);
        wait_cyc(10);
        total++;
        if (tx_q.size() !== 3 || tx_q[0] !== 8'h11 || tx_q[1] !== 8'h22 || tx_q[2] !== 8'h33)
        begin
            bad++; $display("FAIL burst_wrap got=%p want='{11,22,33}", tx_q);
        end
        clear_tx();
        r0 = rd_en_count;
        send_byte(8'hAB); send_byte(8'h02); send_byte(8'h00);
        wait_cyc(6);
        total++;
        if (tx_q.size() !== 0 || rd_en_count !== r0) begin
            bad++; $display("FAIL burst_zero got=push%0d rd%0d want=push0 rd%0d",
                            tx_q.size(), rd_en_count, r0);
        end
    endtask

    task automatic test_backpressure();
        clear_tx();
        alu_val = 16'hBEEF;
        fifo_full = 1'b1;
        send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02); send_byte(8'h05);
        wait_cyc(20);
        total++;
        if (tx_q.size() !== 0) begin
            bad++; $display("FAIL bp_while_full got=%0d want=0", tx_q.size());
        end
        fifo_full = 1'b0;
        wait_cyc(6);
        total++;
        if (tx_q.size() !== 2 || tx_q[0] !== 8'hEF || tx_q[1] !== 8'hBE) begin
            bad++; $display("FAIL bp_release got=%p want='{ef,be}", tx_q);
        end
        total++;
        if (push_cyc.size() !== 2 || push_cyc[1] !== push_cyc[0] + 1) begin
            bad++; $display("FAIL bp_back_to_back got=%p want=consecutive", push_cyc);
        end
    endtask

    task automatic test_timeout_unknown();
        int w0 = wr_count;
        int e0 = err_count;
        int b;
        clear_tx();
        send_byte(8'hAA); send_byte(8'h04);
        b = byte_cyc;
        wait_cyc(25);
        total++;
        if (err_count !== e0 + 1 || err_cyc !== b + 16) begin
            bad++; $display("FAIL tmo_err got=cnt%0d dly%0d want=cnt%0d dly16",
                            err_count, err_cyc - b, e0 + 1);
        end
        total++;
        if (tx_q.size() !== 1 || tx_q[0] !== 8'hFF || wr_count !== w0) begin
            bad++; $display("FAIL tmo_resp got=%p wr%0d want='{ff} wr%0d", tx_q, wr_count, w0);
        end
        clear_tx();
        send_byte(8'h42);
        wait_cyc(4);
        total++;
        if (err_count !== e0 + 2 || err_cyc !== byte_cyc + 1) begin
            bad++; $display("FAIL unk_err got=cnt%0d cyc%0d want=cnt%0d cyc%0d",
                            err_count, err_cyc, e0 + 2, byte_cyc + 1);
        end
        total++;
        if (tx_q.size() !== 1 || tx_q[0] !== 8'hFF) begin
            bad++; $display("FAIL unk_resp got=%p want='{ff}", tx_q);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [29:0] outs;
        clear_tx();
        rd_hold = 1'b1;
        send_byte(8'hAB); send_byte(8'h03); send_byte(8'h05);
        wait_cyc(3);
        rst_n = 1'b0;
        #1;
        outs = {alu_fun, en, clk_en, address, wr_en, rd_en, wr_data, tx_data, w_inc, frame_err};
        total++;
        if (outs !== '0) begin
            bad++; $display("FAIL rst_mid_outputs got=%h want=0", outs);
        end
        wait_cyc(2);
        rst_n = 1'b1;
        rd_hold = 1'b0;
        wait_cyc(3);
        total++;
        if (tx_q.size() !== 0) begin
            bad++; $display("FAIL rst_mid_stale got=%0d want=0", tx_q.size());
        end
        send_byte(8'hBB); send_byte(8'h0E);
        wait_cyc(6);
        total++;
        if (tx_q.size() !== 1 || tx_q[0] !== 8'h11) begin
            bad++; $display("FAIL rst_mid_read got=%p want='{11}", tx_q);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alu();
        test_burst();
        test_backpressure();
        test_timeout_unknown();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
